// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: default reset vector, default widths and the
// fetch entry layout used between the fetch unit and decode.
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam int          INST_W_DEFAULT   = 32;
  localparam int          ADDR_W_DEFAULT   = 32;

  typedef struct packed {
    logic [ADDR_W_DEFAULT-1:0] pc;
    logic [INST_W_DEFAULT-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order instruction buffer with flush; head entry is presented from registers so
// decode never sees a combinational path from the write port.
module fetch_fifo import cpu_pkg::*; #(
  parameter  int DEPTH  = 4,
  parameter  int DATA_W = ADDR_W_DEFAULT + INST_W_DEFAULT,
  localparam int CW     = $clog2(DEPTH + 1),
  localparam int PW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              ready,
  output logic              head_valid,
  output logic [DATA_W-1:0] head_data,
  output logic [CW-1:0]     count
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PW-1:0]     rd_ptr_r, wr_ptr_r, rd_ptr_s, wr_ptr_s;
  logic [CW-1:0]     count_r, count_s;
  logic              head_valid_r;
  logic [DATA_W-1:0] head_data_r, head_data_s;
  logic              pop_s, push_s;

  // Pointers wrap at DEPTH explicitly so non power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  // Next-state for pointers, occupancy and the registered head entry.
  always_comb begin
    pop_s    = head_valid_r && ready;
    push_s   = push && ((count_r < CW'(DEPTH)) || pop_s);
    rd_ptr_s = pop_s ? ptr_inc(rd_ptr_r) : rd_ptr_r;
    wr_ptr_s = push_s ? ptr_inc(wr_ptr_r) : wr_ptr_r;
    count_s  = count_r + CW'(push_s) - CW'(pop_s);
    if (count_s == {CW{1'b0}}) begin
      head_data_s = head_data_r;
    end else if (push_s && ((count_r - CW'(pop_s)) == {CW{1'b0}})) begin
      head_data_s = wdata;
    end else begin
      head_data_s = mem_r[rd_ptr_s];
    end
    if (flush) begin
      rd_ptr_s = {PW{1'b0}};
      wr_ptr_s = {PW{1'b0}};
      count_s  = {CW{1'b0}};
    end else begin
      count_s  = count_s;
    end
  end

  // Entry storage, written at the tail.
  always_ff @(posedge clk) begin
    if (push_s && !flush) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Control state and registered head.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_r     <= {PW{1'b0}};
      wr_ptr_r     <= {PW{1'b0}};
      count_r      <= {CW{1'b0}};
      head_valid_r <= 1'b0;
      head_data_r  <= {DATA_W{1'b0}};
    end else begin
      rd_ptr_r     <= rd_ptr_s;
      wr_ptr_r     <= wr_ptr_s;
      count_r      <= count_s;
      head_valid_r <= (count_s != {CW{1'b0}});
      head_data_r  <= head_data_s;
    end
  end

  assign head_valid = head_valid_r;
  assign head_data  = head_data_r;
  assign count      = count_r;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: sequential PC generation, credit-limited outstanding
// requests, in-order response buffering and single-cycle redirect with discard.
module fetch_queue import cpu_pkg::*; #(
  parameter  int              ADDR_W   = ADDR_W_DEFAULT,
  parameter  int              INST_W   = INST_W_DEFAULT,
  parameter  int              DEPTH    = 4,
  parameter  logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT),
  localparam int              CW       = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);

  logic [ADDR_W-1:0]        fetch_pc_r, resp_pc_r;
  logic [CW-1:0]            inflight_r, discard_r, occ_s;
  logic [CW:0]              live_s;
  logic                     rvalid_s, grant_s, push_s, credit_s;
  logic [ADDR_W+INST_W-1:0] head_s;

  // Credit check counts buffered entries plus live (non-discarded) requests.
  always_comb begin
    rvalid_s = imem_rvalid && (inflight_r != {CW{1'b0}});
    live_s   = {1'b0, occ_s} + {1'b0, inflight_r} - {1'b0, discard_r};
    credit_s = (live_s < (CW + 1)'(DEPTH));
    imem_req = rst && !redirect_valid && credit_s;
    grant_s  = imem_req && imem_gnt;
    push_s   = rvalid_s && (discard_r == {CW{1'b0}}) && !redirect_valid;
  end

  assign imem_addr = fetch_pc_r;

  // PC generator, outstanding-request bookkeeping and redirect handling.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_r <= RESET_PC;
      resp_pc_r  <= RESET_PC;
      inflight_r <= {CW{1'b0}};
      discard_r  <= {CW{1'b0}};
    end else if (redirect_valid) begin
      // Everything still outstanding after this cycle belongs to the old path.
      fetch_pc_r <= {redirect_pc[ADDR_W-1:2], 2'b00};
      resp_pc_r  <= {redirect_pc[ADDR_W-1:2], 2'b00};
      inflight_r <= inflight_r - CW'(rvalid_s);
      discard_r  <= inflight_r - CW'(rvalid_s);
    end else begin
      if (grant_s) begin
        fetch_pc_r <= fetch_pc_r + ADDR_W'(4);
      end
      inflight_r <= inflight_r + CW'(grant_s) - CW'(rvalid_s);
      if (rvalid_s && (discard_r != {CW{1'b0}})) begin
        discard_r <= discard_r - CW'(1);
      end
      if (push_s) begin
        resp_pc_r <= resp_pc_r + ADDR_W'(4);
      end
    end
  end

  fetch_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (ADDR_W + INST_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push       (push_s),
    .wdata      ({resp_pc_r, imem_rdata}),
    .ready      (out_ready),
    .head_valid (out_valid),
    .head_data  (head_s),
    .count      (occ_s)
  );

  assign out_pc   = head_s[ADDR_W+INST_W-1:INST_W];
  assign out_inst = head_s[INST_W-1:0];

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised and directed bench for fetch_queue against a request-tag queue model.
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req, imem_gnt, imem_rvalid, out_valid, out_ready, redirect_valid;
  logic [31:0] imem_addr, imem_rdata, out_inst, out_pc, redirect_pc;

  always #5 clk = ~clk;

  fetch_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  int checks = 0, failures = 0, cyc = 0;

  // Model: expected decode queue, and outstanding requests tagged keep/drop.
  logic [31:0] m_fetch_pc;
  logic [31:0] oq_pc[$], oq_inst[$];
  logic [31:0] os_pc[$];
  bit          os_keep[$];
  // Memory: granted addresses with the cycle they may return.
  logic [31:0] mq_addr[$];
  int          mq_due[$];

  logic        obs_valid, last_req, last_gnt;
  logic [31:0] obs_pc, last_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic int keep_count();
    int n = 0;
    foreach (os_keep[i]) if (os_keep[i]) n++;
    return n;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  task automatic clear_model();
    oq_pc.delete(); oq_inst.delete(); os_pc.delete(); os_keep.delete();
    mq_addr.delete(); mq_due.delete();
    m_fetch_pc = RESET_PC;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    clear_model();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // One clock cycle: check outputs, drive inputs, advance memory and model.
  task automatic step(input bit redir, input logic [31:0] rpc, input bit ready,
                      input bit gnt, input int lat, input bit bogus);
    bit          exp_req, rv, pop, k;
    logic [31:0] rdata, pc;
    @(negedge clk);
    check("out_valid", 32'(out_valid), 32'(oq_pc.size() > 0));
    obs_valid = out_valid;
    obs_pc    = out_pc;
    if (oq_pc.size() > 0) begin
      check("out_pc", out_pc, oq_pc[0]);
      check("out_inst", out_inst, oq_inst[0]);
    end
    redirect_valid = redir; redirect_pc = rpc; out_ready = ready; imem_gnt = gnt;
    rv = 1'b0; rdata = $urandom;
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      rv = 1'b1; rdata = mem_word(mq_addr[0]);
    end else if (bogus && mq_addr.size() == 0) begin
      rv = 1'b1;
    end
    imem_rvalid = rv; imem_rdata = rdata;
    #1;
    exp_req = !redir && (oq_pc.size() + keep_count() < DEPTH);
    check("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) check("imem_addr", imem_addr, m_fetch_pc);
    last_req = imem_req; last_addr = imem_addr; last_gnt = imem_req && gnt;
    pop = (oq_pc.size() > 0) && ready;
    if (rv && mq_addr.size() > 0) begin
      void'(mq_addr.pop_front()); void'(mq_due.pop_front());
    end
    if (imem_req && gnt) begin
      mq_addr.push_back(imem_addr); mq_due.push_back(cyc + lat);
    end
    if (redir) begin
      oq_pc.delete(); oq_inst.delete();
      if (rv && os_pc.size() > 0) begin
        void'(os_pc.pop_front()); void'(os_keep.pop_front());
      end
      for (int i = 0; i < os_keep.size(); i++) os_keep[i] = 1'b0;
      m_fetch_pc = {rpc[31:2], 2'b00};
    end else begin
      if (pop) begin
        void'(oq_pc.pop_front()); void'(oq_inst.pop_front());
      end
      if (rv && os_pc.size() > 0) begin
        pc = os_pc.pop_front(); k = os_keep.pop_front();
        if (k) begin oq_pc.push_back(pc); oq_inst.push_back(rdata); end
      end
      if (exp_req && gnt) begin
        os_pc.push_back(m_fetch_pc); os_keep.push_back(1'b1);
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
    @(posedge clk);
    cyc++;
  endtask

  // After a redirect: first request and first delivered entry must be at target.
  task automatic seek(input logic [31:0] target, input int lat, input string nm);
    bit got_req = 1'b0, got_val = 1'b0;
    for (int i = 0; i < 30 && !(got_req && got_val); i++) begin
      step(1'b0, 32'd0, 1'b1, 1'b1, lat, 1'b0);
      if (!got_val && obs_valid) begin got_val = 1'b1; check({nm, "_first_pc"}, obs_pc, target); end
      if (!got_req && last_req) begin got_req = 1'b1; check({nm, "_first_addr"}, last_addr, target); end
    end
    check({nm, "_seen"}, {30'd0, got_req, got_val}, 32'd3);
  endtask

  logic [31:0] addrs[6], pcs[6];
  logic        vld[6];
  int          grants;

  initial begin
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'd0;
    do_reset();

    // Streaming with a one-cycle memory.
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 32'd0, 1'b1, 1'b1, 1, 1'b0);
      addrs[i] = last_addr; vld[i] = obs_valid; pcs[i] = obs_pc;
    end
    check("stream_addr0", addrs[0], 32'hBFC0_0000);
    check("stream_addr1", addrs[1], 32'hBFC0_0004);
    check("stream_valid1", 32'(vld[1]), 32'd0);
    check("stream_valid2", 32'(vld[2]), 32'd1);
    check("stream_pc2", pcs[2], 32'hBFC0_0000);
    check("stream_pc3", pcs[3], 32'hBFC0_0004);

    // Part-fill the queue, then reset mid-stream.
    repeat (2) step(1'b0, 32'd0, 1'b0, 1'b1, 1, 1'b0);
    do_reset();

    // Stall decode: exactly DEPTH grants, then drain in order.
    grants = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 32'd0, 1'b0, 1'b1, 1, 1'b0);
      if (i == 0) check("reset_first_addr", last_addr, RESET_PC);
      if (last_gnt) grants++;
    end
    check("stall_grants", 32'(grants), 32'd4);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'd0, 1'b1, 1'b1, 1, 1'b0);
      check("drain_pc", obs_pc, RESET_PC + 32'(4 * i));
    end

    // Redirect with three requests outstanding.
    repeat (8) step(1'b0, 32'd0, 1'b1, 1'b1, 3, 1'b0);
    step(1'b1, 32'h8000_0102, 1'b1, 1'b1, 3, 1'b0);
    seek(32'h8000_0100, 3, "redir3");

    // Redirect coinciding with a response while two are outstanding.
    repeat (8) step(1'b0, 32'd0, 1'b1, 1'b1, 2, 1'b0);
    step(1'b1, 32'h0000_1000, 1'b1, 1'b1, 2, 1'b0);
    seek(32'h0000_1000, 2, "redir_rv");

    // Address wrap at the top of the space.
    step(1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1, 1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b1, 1, 1'b0);
    check("wrap_addr_hi", last_addr, 32'hFFFF_FFFC);
    step(1'b0, 32'd0, 1'b1, 1'b1, 1, 1'b0);
    check("wrap_addr_lo", last_addr, 32'h0000_0000);

    // Randomised traffic with occasional redirects, spurious responses and resets.
    for (int i = 0; i < 3000; i++) begin
      if (i % 1000 == 999) do_reset();
      step($urandom_range(0, 99) < 3, $urandom, ($urandom % 4) != 0,
           ($urandom % 4) != 0, $urandom_range(1, 3), ($urandom % 8) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised instruction-fetch front end that replaces the single-cycle PC/instruction-register pair of the current core.
- Generates sequential fetch addresses and tracks up to DEPTH outstanding instruction-memory requests.
- Buffers returned instructions with their PCs in an in-order queue and presents them to decode through a valid/ready handshake.
- Supports a single-cycle redirect (branch/jump/jr) that flushes buffered and in-flight instructions.

Parameters:
- ADDR_W, 32, fetch address width in bits.
- INST_W, 32, instruction width in bits.
- DEPTH, 4, queue entries, which is also the maximum outstanding requests; must be 2 or more.
- RESET_PC, 32'hBFC0_0000, first fetch address after reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  ADDR_W  fetch address; bits [1:0] always 0.
- imem_gnt  in  1  request accepted this cycle when imem_req=1.
- imem_rvalid  in  1  response valid; responses return in request order, at least 1 cycle after grant.
- imem_rdata  in  INST_W  response instruction.
- out_valid  out  1  queue head valid.
- out_ready  in  1  decode consumes the head when out_valid=1.
- out_inst  out  INST_W  head instruction.
- out_pc  out  ADDR_W  head instruction address.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  ADDR_W  new fetch address; bits [1:0] are ignored and forced to 0.

Behaviour:
- Reset values, applied asynchronously while rst=0:
  - fetch_pc = RESET_PC and resp_pc = RESET_PC.
  - occupancy, inflight and discard counters = 0.
  - imem_req=0, out_valid=0, out_inst=0, out_pc=0.
- First request is issued in the first cycle after rst deasserts.
- Credit rule: imem_req = !redirect_valid && (occupancy + inflight - discard < DEPTH).
  - This guarantees the queue never overflows.
  - Counters are $clog2(DEPTH+1) bits wide.
- imem_addr = fetch_pc. imem_req is combinational from registered state and redirect_valid.
- On imem_req && imem_gnt: fetch_pc += 4 (wraps modulo 2^ADDR_W), inflight += 1.
- On imem_rvalid:
  - inflight -= 1.
  - If discard > 0: discard -= 1 and the data is dropped.
  - Otherwise push {resp_pc, imem_rdata} into the queue and resp_pc += 4.
- imem_rvalid while inflight==0 is a protocol error; ignore it with no state change.
- Pop on out_valid && out_ready. out_inst and out_pc show the head entry, registered from queue storage.
- Latency: a response pushed in cycle N is visible as out_valid in cycle N+1 when the queue was empty. There is no combinational rdata-to-out path.
- Simultaneous push and pop at any occupancy is legal and leaves occupancy unchanged.
- Redirect (has priority over everything else in the cycle):
  - No request is issued in that cycle.
  - Queue is flushed: occupancy=0, and out_valid=0 from the next cycle.
  - A pop in the redirect cycle is still honoured by decode; the queue state is discarded regardless.
  - discard <= inflight - imem_rvalid. Any response arriving in the redirect cycle is dropped and all remaining in-flight responses are marked for discard.
  - fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00}, and resp_pc takes the same value.
  - Fetch resumes next cycle, subject to the credit rule.
- Back-to-back redirects: each one overrides the previous; the discard count is recomputed from the current inflight.
- Reset mid-operation: all state is cleared. The instruction memory is reset by the same rst, so no stale responses arrive afterwards.
- Full queue with out_ready=0: imem_req stays low and no state changes except response arrivals for already-credited requests.

Decomposition:
- Shared package cpu_pkg holds RESET_PC_DEFAULT, INST_W_DEFAULT, and the fetch entry struct {pc, inst}.
- Natural sub-module: fetch_fifo.
  - Synchronous FIFO of DEPTH entries with a flush input.
  - Read and write pointers wrap modulo DEPTH; DEPTH need not be a power of 2.
  - Registered head output.
- fetch_queue holds the PC generator, the credit/inflight/discard counters and the redirect logic.

Test Plan:
- Reset release, imem_gnt=1, 1-cycle memory, out_ready=1 -> addresses 0xBFC00000, 0xBFC00004, ... on consecutive cycles; out_pc follows two cycles behind each request with matching out_inst.
- out_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 grants, then imem_req=0. Occupancy holds at 4. After out_ready=1, the 4 entries drain in order before new ones appear.
- Redirect to 0x80000102 with 3 requests in flight -> the next 3 rvalids are dropped, the next request address is 0x80000100, and the first out_pc is 0x80000100.
- imem_rvalid and redirect_valid in the same cycle with inflight=2 -> that response is dropped and discard=1. Only data from post-redirect requests reaches out_inst.
- rst pulsed low mid-stream with the queue half full -> out_valid=0 immediately, and the first request after release is to RESET_PC.
- fetch_pc at 0xFFFFFFFC -> the next address is 0x00000000 with no stall or error.
